// File: rtl/ddr2_app_line_cache_interface.sv
// Client front-end to the MIG app interface: narrow read/write requests mapped onto 128-bit lines
// (two 64-bit beats), with an optional one-line read cache and write-through byte-masked writes.
module ddr2_app_line_cache_interface #(
    parameter int ADDR_W      = 27,
    parameter int USER_DATA_W = 8,
    parameter int CACHE_EN    = 1
) (
    input  logic                   ui_clk_i,
    input  logic                   ui_rst_i,
    input  logic                   init_calib_complete_i,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic                   req_we_i,
    input  logic [ADDR_W-1:0]      req_addr_i,
    input  logic [USER_DATA_W-1:0] req_wdata_i,
    output logic                   rsp_valid_o,
    output logic [USER_DATA_W-1:0] rsp_rdata_o,
    output logic                   idle_o,
    output logic [ADDR_W-1:0]      app_addr_o,
    output logic [2:0]             app_cmd_o,
    output logic                   app_en_o,
    input  logic                   app_rdy_i,
    output logic [63:0]            app_wdf_data_o,
    output logic [7:0]             app_wdf_mask_o,
    output logic                   app_wdf_wren_o,
    output logic                   app_wdf_end_o,
    input  logic                   app_wdf_rdy_i,
    input  logic [63:0]            app_rd_data_i,
    input  logic                   app_rd_data_valid_i,
    input  logic                   app_rd_data_end_i
);
    localparam int          NBYTES = USER_DATA_W / 8;
    localparam logic [15:0] BE     = 16'((1 << NBYTES) - 1);

    typedef enum logic [2:0] {
        WAIT_CALIB, IDLE, RD_CMD, RD_WAIT, RESP, WR_CMD, WR_L, WR_H
    } state_t;

    state_t                   r_state, w_state_next;
    logic [127:0]             r_line;
    logic [ADDR_W-5:0]        r_tag;
    logic                     r_line_valid;
    logic [ADDR_W-1:0]        r_addr;
    logic [USER_DATA_W-1:0]   r_wdata;
    logic                     r_rsp_valid;
    logic [USER_DATA_W-1:0]   r_rsp_rdata;

    logic [ADDR_W-1:0]        w_req_addr;
    logic [3:0]               w_req_off;
    logic [15:0]              w_req_mask;
    logic [15:0]              w_cur_mask;
    logic                     w_accept;
    logic                     w_hit;
    logic [127:0]             w_wdata_line;
    logic [127:0]             w_fill_line;

    // Sub-word address bits are dropped so every access is naturally aligned.
    assign w_req_addr   = req_addr_i & ~(ADDR_W'(NBYTES - 1));
    assign w_req_off    = w_req_addr[3:0];
    assign w_req_mask   = ~(BE << w_req_off);
    assign w_cur_mask   = ~(BE << r_addr[3:0]);
    assign w_accept     = req_valid_i && (r_state == IDLE);
    assign w_hit        = (CACHE_EN != 0) && r_line_valid && (r_tag == w_req_addr[ADDR_W-1:4]);
    assign w_wdata_line = {(128 / USER_DATA_W){req_wdata_i}};
    assign w_fill_line  = {app_rd_data_i, r_line[63:0]};

    assign req_ready_o    = (r_state == IDLE);
    assign idle_o         = (r_state == IDLE);
    assign rsp_valid_o    = r_rsp_valid;
    assign rsp_rdata_o    = r_rsp_rdata;
    assign app_addr_o     = {r_addr[ADDR_W-1:4], 4'b0000};
    assign app_wdf_data_o = {(64 / USER_DATA_W){r_wdata}};

    always_ff @(posedge ui_clk_i) begin
        if (ui_rst_i) r_state <= WAIT_CALIB;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next   = r_state;
        app_en_o       = 1'b0;
        app_cmd_o      = 3'b000;
        app_wdf_wren_o = 1'b0;
        app_wdf_end_o  = 1'b0;
        app_wdf_mask_o = 8'hFF;
        case (r_state)
            WAIT_CALIB: if (init_calib_complete_i) w_state_next = IDLE;
            IDLE: begin
                if (w_accept) begin
                    if (req_we_i)    w_state_next = WR_CMD;
                    else if (!w_hit) w_state_next = RD_CMD;
                end
            end
            RD_CMD: begin
                app_en_o  = 1'b1;
                app_cmd_o = 3'b001;
                if (app_rdy_i) w_state_next = RD_WAIT;
            end
            RD_WAIT: if (app_rd_data_valid_i && app_rd_data_end_i) w_state_next = RESP;
            RESP:    w_state_next = IDLE;
            WR_CMD: begin
                app_en_o = 1'b1;
                if (app_rdy_i) w_state_next = WR_L;
            end
            WR_L: begin
                app_wdf_wren_o = 1'b1;
                app_wdf_mask_o = w_cur_mask[7:0];
                if (app_wdf_rdy_i) w_state_next = WR_H;
            end
            WR_H: begin
                app_wdf_wren_o = 1'b1;
                app_wdf_end_o  = 1'b1;
                app_wdf_mask_o = w_cur_mask[15:8];
                if (app_wdf_rdy_i) w_state_next = IDLE;
            end
            default: w_state_next = WAIT_CALIB;
        endcase
    end

    always_ff @(posedge ui_clk_i) begin
        if (ui_rst_i) begin
            r_line       <= '0;
            r_tag        <= '0;
            r_line_valid <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_rdata  <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            if (w_accept) begin
                r_addr  <= w_req_addr;
                r_wdata <= req_wdata_i;
                if (!req_we_i && w_hit) begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_rdata <= r_line[{w_req_off, 3'b000} +: USER_DATA_W];
                end
                // Write-through keeps the cached copy coherent; misses do not allocate.
                if (req_we_i && w_hit) begin
                    for (int b = 0; b < 16; b++) begin
                        if (!w_req_mask[b]) r_line[b*8 +: 8] <= w_wdata_line[b*8 +: 8];
                    end
                end
            end
            if (r_state == RD_WAIT && app_rd_data_valid_i) begin
                if (!app_rd_data_end_i) begin
                    r_line[63:0] <= app_rd_data_i;
                end else begin
                    r_line[127:64] <= app_rd_data_i;
                    r_tag          <= r_addr[ADDR_W-1:4];
                    r_line_valid   <= 1'b1;
                    r_rsp_valid    <= 1'b1;
                    r_rsp_rdata    <= w_fill_line[{r_addr[3:0], 3'b000} +: USER_DATA_W];
                end
            end
        end
    end
endmodule
